// File: rtl/food_placer.sv
// Turns the free-running LFSR x/y stream into a legal, unoccupied food cell.
// Random candidates are tried first; after MAX_TRIES rejections a raster scan takes over.
module food_placer #(
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 16,
  parameter int unsigned MAX_TRIES = 32,
  parameter logic [3:0]  INIT_X    = 4'd12,
  parameter logic [3:0]  INIT_Y    = 4'd8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_rand_x,
  input  logic [3:0] i_rand_y,
  input  logic       i_place_req,
  output logic       o_busy,
  output logic       o_food_valid,
  output logic [3:0] o_food_x,
  output logic [3:0] o_food_y,
  output logic       o_place_done,
  output logic       o_board_full,
  output logic       o_occ_req,
  output logic [3:0] o_occ_x,
  output logic [3:0] o_occ_y,
  input  logic       i_occ_ack,
  input  logic       i_occ_hit
);

  localparam logic [4:0] W_LIM   = 5'(GRID_W);
  localparam logic [4:0] H_LIM   = 5'(GRID_H);
  localparam logic [3:0] X_MAX   = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX   = 4'(GRID_H - 1);
  localparam logic [7:0] TRY_LIM = 8'(MAX_TRIES);
  localparam logic [8:0] AREA    = 9'(GRID_W * GRID_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_QUERY,
    S_SCAN
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [3:0] scan_x_q, scan_x_d, scan_y_q, scan_y_d;
  logic [3:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic       queried_q, queried_d;
  logic [7:0] tries_q, tries_d;
  logic [8:0] scan_cnt_q, scan_cnt_d;
  logic [3:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;
  logic       done_q, done_d;
  logic       full_q, full_d;

  logic       in_range;
  logic [7:0] tries_inc;
  logic [8:0] scan_inc;

  // Raster order: x first, then y; both wrap inside the grid.
  function automatic logic [7:0] scan_next(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] nx, ny;
    if (x == X_MAX) begin
      nx = '0;
      ny = (y == Y_MAX) ? '0 : y + 4'd1;
    end else begin
      nx = x + 4'd1;
      ny = y;
    end
    return {ny, nx};
  endfunction

  assign in_range  = ({1'b0, i_rand_x} < W_LIM) && ({1'b0, i_rand_y} < H_LIM);
  assign tries_inc = tries_q + 8'd1;
  assign scan_inc  = scan_cnt_q + 9'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    queried_d    = queried_q;
    tries_d      = tries_q;
    scan_cnt_d   = scan_cnt_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    done_d       = 1'b0;
    full_d       = full_q;

    case (state_q)
      S_IDLE: begin
        if (i_place_req) begin
          state_d      = S_SAMPLE;
          food_valid_d = 1'b0;
          full_d       = 1'b0;
          tries_d      = '0;
          scan_cnt_d   = '0;
          queried_d    = 1'b0;
        end
      end
      S_SAMPLE: begin
        cand_x_d = i_rand_x;
        cand_y_d = i_rand_y;
        if (in_range) begin
          state_d = S_QUERY;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == TRY_LIM) begin
            state_d = S_SCAN;
            if (queried_q) {scan_y_d, scan_x_d} = scan_next(last_x_q, last_y_q);
            else           {scan_y_d, scan_x_d} = '0;
          end
        end
      end
      S_QUERY: begin
        if (i_occ_ack) begin
          queried_d = 1'b1;
          last_x_d  = cand_x_q;
          last_y_d  = cand_y_q;
          if (i_occ_hit) begin
            tries_d = tries_inc;
            if (tries_inc == TRY_LIM) begin
              // The candidate just acked is the last queried one.
              state_d = S_SCAN;
              {scan_y_d, scan_x_d} = scan_next(cand_x_q, cand_y_q);
            end else begin
              state_d = S_SAMPLE;
            end
          end else begin
            state_d      = S_IDLE;
            food_x_d     = cand_x_q;
            food_y_d     = cand_y_q;
            food_valid_d = 1'b1;
            done_d       = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (i_occ_ack) begin
          if (!i_occ_hit) begin
            state_d      = S_IDLE;
            food_x_d     = scan_x_q;
            food_y_d     = scan_y_q;
            food_valid_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            scan_cnt_d = scan_inc;
            if (scan_inc == AREA) begin
              state_d      = S_IDLE;
              full_d       = 1'b1;
              food_valid_d = 1'b0;
            end else begin
              {scan_y_d, scan_x_d} = scan_next(scan_x_q, scan_y_q);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      last_x_q     <= '0;
      last_y_q     <= '0;
      queried_q    <= 1'b0;
      tries_q      <= '0;
      scan_cnt_q   <= '0;
      food_x_q     <= INIT_X;
      food_y_q     <= INIT_Y;
      food_valid_q <= 1'b1;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      queried_q    <= queried_d;
      tries_q      <= tries_d;
      scan_cnt_q   <= scan_cnt_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      done_q       <= done_d;
      full_q       <= full_d;
    end
  end

  always_comb begin
    o_busy    = (state_q != S_IDLE);
    o_occ_req = 1'b0;
    o_occ_x   = '0;
    o_occ_y   = '0;
    case (state_q)
      S_QUERY: begin
        o_occ_req = 1'b1;
        o_occ_x   = cand_x_q;
        o_occ_y   = cand_y_q;
      end
      S_SCAN: begin
        o_occ_req = 1'b1;
        o_occ_x   = scan_x_q;
        o_occ_y   = scan_y_q;
      end
      default: ;
    endcase
  end

  assign o_food_valid = food_valid_q;
  assign o_food_x     = food_x_q;
  assign o_food_y     = food_y_q;
  assign o_place_done = done_q;
  assign o_board_full = full_q;

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: three instances (16x16/2 tries, 10x10, 4x4/2 tries),
// an occupancy responder with programmable ack delay, and a monitor popping expected queries/results.
module tb_food_placer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req  [3];
  logic [3:0] rx   [3];
  logic [3:0] ry   [3];
  logic       ack  [3];
  logic       hit  [3];
  logic       busy [3];
  logic       fv   [3];
  logic [3:0] fx   [3];
  logic [3:0] fy   [3];
  logic       done [3];
  logic       full [3];
  logic       oreq [3];
  logic [3:0] ox   [3];
  logic [3:0] oy   [3];

  food_placer #(.GRID_W(16), .GRID_H(16), .MAX_TRIES(2)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rand_x(rx[0]), .i_rand_y(ry[0]), .i_place_req(req[0]),
    .o_busy(busy[0]), .o_food_valid(fv[0]), .o_food_x(fx[0]), .o_food_y(fy[0]),
    .o_place_done(done[0]), .o_board_full(full[0]), .o_occ_req(oreq[0]),
    .o_occ_x(ox[0]), .o_occ_y(oy[0]), .i_occ_ack(ack[0]), .i_occ_hit(hit[0]));

  food_placer #(.GRID_W(10), .GRID_H(10), .MAX_TRIES(32), .INIT_X(4'd5), .INIT_Y(4'd8)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rand_x(rx[1]), .i_rand_y(ry[1]), .i_place_req(req[1]),
    .o_busy(busy[1]), .o_food_valid(fv[1]), .o_food_x(fx[1]), .o_food_y(fy[1]),
    .o_place_done(done[1]), .o_board_full(full[1]), .o_occ_req(oreq[1]),
    .o_occ_x(ox[1]), .o_occ_y(oy[1]), .i_occ_ack(ack[1]), .i_occ_hit(hit[1]));

  food_placer #(.GRID_W(4), .GRID_H(4), .MAX_TRIES(2), .INIT_X(4'd1), .INIT_Y(4'd1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_rand_x(rx[2]), .i_rand_y(ry[2]), .i_place_req(req[2]),
    .o_busy(busy[2]), .o_food_valid(fv[2]), .o_food_x(fx[2]), .o_food_y(fy[2]),
    .o_place_done(done[2]), .o_board_full(full[2]), .o_occ_req(oreq[2]),
    .o_occ_x(ox[2]), .o_occ_y(oy[2]), .i_occ_ack(ack[2]), .i_occ_hit(hit[2]));

  typedef struct {
    int k;
    bit is_full;
    int x;
    int y;
  } res_t;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         expq [$];
  res_t       expr [$];
  logic [7:0] rseq [$];
  bit [255:0] occ;
  int         ack_dly;
  int         wcnt [3];
  bit         pend [3];
  int         pxy  [3];
  bit         full_seen [3];
  int         init_x [3] = '{12, 5, 1};
  int         init_y [3] = '{8, 8, 1};

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Occupancy unit model: acks after ack_dly wait cycles, hit from the occ bitmap.
  always begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || oreq[k] !== 1'b1) begin
        ack[k]  = 1'b0;
        hit[k]  = 1'b0;
        wcnt[k] = 0;
      end else if (wcnt[k] >= ack_dly) begin
        ack[k]  = 1'b1;
        hit[k]  = occ[{oy[k], ox[k]}];
        wcnt[k] = 0;
      end else begin
        ack[k]  = 1'b0;
        hit[k]  = 1'b0;
        wcnt[k] = wcnt[k] + 1;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      if (rst_n) begin
        if (pend[k]) begin
          chk("occ_req_held", int'(oreq[k]), 1);
          chk("occ_xy_stable", int'({ox[k], oy[k]}), pxy[k]);
        end
        if (oreq[k] && ack[k]) begin
          if (expq.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_query: dut%0d got (%0d,%0d), expected none", k, ox[k], oy[k]);
          end else begin
            chk("query", k * 256 + int'(ox[k]) * 16 + int'(oy[k]), expq.pop_front());
          end
        end
        pend[k] = oreq[k] && !ack[k];
        pxy[k]  = int'({ox[k], oy[k]});
        if (done[k] || (full[k] && !full_seen[k])) begin
          if (expr.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_result: dut%0d done=%0d full=%0d, expected none", k, done[k], full[k]);
          end else begin
            res_t r;
            r = expr.pop_front();
            chk("res_dut", k, r.k);
            chk("res_full", int'(full[k]), int'(r.is_full));
            chk("res_done", int'(done[k]), int'(!r.is_full));
            chk("res_valid", int'(fv[k]), int'(!r.is_full));
            if (!r.is_full) chk("res_food_xy", int'(fx[k]) * 16 + int'(fy[k]), r.x * 16 + r.y);
          end
        end
        full_seen[k] = full[k];
      end else begin
        pend[k]      = 1'b0;
        full_seen[k] = 1'b0;
      end
    end
  end

  task automatic drive_rand(input int k, input int c);
    logic [7:0] v;
    if (c < rseq.size()) v = rseq[c];
    else                 v = 8'(c * 37 + 11);
    {rx[k], ry[k]} = v;
  endtask

  task automatic push_q(input int k, input int x, input int y);
    expq.push_back(k * 256 + x * 16 + y);
  endtask

  task automatic push_r(input int k, input bit f, input int x, input int y);
    res_t r;
    r.k = k; r.is_full = f; r.x = x; r.y = y;
    expr.push_back(r);
  endtask

  // Request in cycle 0, rand from rseq per cycle; returns the cycle a result appeared.
  task automatic run(input int k, input int req_len, input int rst_at, input int max_cyc, output int cyc);
    cyc = 0;
    req[k] = 1'b1;
    drive_rand(k, 0);
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      req[k] = (cyc < req_len);
      drive_rand(k, cyc);
      if (rst_at > 0 && cyc == rst_at) begin
        chk("busy_before_rst", int'(busy[k]), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        break;
      end
      if (done[k] || full[k]) break;
      if (cyc >= max_cyc) begin
        n_vec++;
        n_miss++;
        $display("FAIL timeout: dut%0d no result after %0d cycles, expected one", k, cyc);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst_n   = 1'b0;
    ack_dly = 0;
    occ     = '0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0;
      rx[k]  = '0;
      ry[k]  = '0;
    end
    idle(2);
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      chk("rst_food_x", int'(fx[k]), init_x[k]);
      chk("rst_food_y", int'(fy[k]), init_y[k]);
      chk("rst_valid", int'(fv[k]), 1);
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_done", int'(done[k]), 0);
      chk("rst_full", int'(full[k]), 0);
      chk("rst_occ_req", int'(oreq[k]), 0);
      chk("rst_occ_xy", int'({ox[k], oy[k]}), 0);
    end

    // Free first candidate; request held into SAMPLE/QUERY must be ignored.
    rseq = '{8'h00, 8'h35};
    push_q(0, 3, 5);
    push_r(0, 0, 3, 5);
    run(0, 3, 0, 50, cyc);
    chk("free_latency", cyc, 3);
    idle(1);
    chk("done_one_pulse", int'(done[0]), 0);
    chk("busy_req_ignored", int'(busy[0]), 0);
    idle(2);

    // Ack stalled 4 cycles while the LFSR keeps moving.
    ack_dly = 4;
    rseq = '{8'h00, 8'h62};
    push_q(0, 6, 2);
    push_r(0, 0, 6, 2);
    run(0, 1, 0, 50, cyc);
    chk("stall_latency", cyc, 7);
    ack_dly = 0;
    idle(2);

    // Two random hits, then scan resumes after (15,0) at (0,1).
    occ = '1;
    occ[8'h10] = 1'b0;
    rseq = '{8'h00, 8'h55, 8'h00, 8'hF0};
    push_q(0, 5, 5);
    push_q(0, 15, 0);
    push_q(0, 0, 1);
    push_r(0, 0, 0, 1);
    run(0, 1, 0, 50, cyc);
    chk("scan_latency", cyc, 6);
    idle(2);

    // Out-of-range candidates on a 10x10 grid are dropped without a query.
    occ = '0;
    rseq = '{8'h00, 8'hC2, 8'h4B, 8'h77};
    push_q(1, 7, 7);
    push_r(1, 0, 7, 7);
    run(1, 1, 0, 50, cyc);
    chk("range_latency", cyc, 5);
    idle(2);

    // Full 4x4 board: 2 random queries then all 16 cells from (0,0).
    occ = '1;
    rseq = '{8'h00, 8'h12, 8'h00, 8'h33};
    push_q(2, 1, 2);
    push_q(2, 3, 3);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        push_q(2, x, y);
    push_r(2, 1, 0, 0);
    run(2, 1, 0, 60, cyc);
    chk("full_latency", cyc, 21);
    idle(2);
    chk("full_holds", int'(full[2]), 1);
    chk("full_valid_low", int'(fv[2]), 0);

    // Next request clears the full flag and finds the freed cell.
    occ[8'h12] = 1'b0;
    rseq = '{8'h00, 8'h21};
    push_q(2, 2, 1);
    push_r(2, 0, 2, 1);
    run(2, 1, 0, 50, cyc);
    chk("refill_latency", cyc, 3);
    chk("refill_full_clr", int'(full[2]), 0);
    idle(2);

    // Reset in the middle of a scan restores the INIT cell.
    occ = '1;
    rseq = '{8'h00, 8'h11, 8'h00, 8'h22};
    push_q(0, 1, 1);
    push_q(0, 2, 2);
    push_q(0, 3, 2);
    push_q(0, 4, 2);
    push_q(0, 5, 2);
    run(0, 1, 8, 50, cyc);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_occ_req", int'(oreq[0]), 0);
    chk("mid_rst_food", int'(fx[0]) * 16 + int'(fy[0]), 12 * 16 + 8);
    chk("mid_rst_valid", int'(fv[0]), 1);
    idle(3);

    chk("query_queue_empty", expq.size(), 0);
    chk("result_queue_empty", expr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
